// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package fetch_pkg;

  typedef logic [31:0] u32;
  typedef logic [63:0] u64;
  typedef u64          addr_t;

  // Default reset PC and the canonical bubble instruction (addi x0,x0,0).
  localparam addr_t PC_INIT_DEFAULT   = 64'h0000_0000_8000_0000;
  localparam u32    NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Bundle handed from fetch to decode.
  typedef struct packed {
    logic  valid;
    addr_t pc;
    u32    raw_instr;
  } fetch_data_t;

  // Branch/jump redirect coming back from execute.
  typedef struct packed {
    logic  valid;
    addr_t pc;
  } redirect_t;

  // REQ : request outstanding on the bus
  // HOLD: a response arrived under stall and sits in the skid buffer
  // DROP: a redirect arrived while a request was in flight; its response is junk
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are ignored.
  function automatic addr_t align_word(input addr_t a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-bus handshake between the fetch stage (master) and memory (slave).
interface fetch_if
  import fetch_pkg::*;
  ;

  logic  ireq_valid;
  addr_t ireq_addr;
  logic  iresp_data_ok;
  u32    iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );

endinterface

// File: rtl/fetch_buf.sv
// Single-entry skid buffer holding one fetched {pc, raw_instr} while decode stalls.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  clear,
  input  addr_t load_pc,
  input  u32    load_instr,
  output logic  full,
  output addr_t buf_pc,
  output u32    buf_instr
);

  logic  full_reg;
  addr_t pc_reg;
  u32    instr_reg;

  // Clear wins over load so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_reg  <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (clear) begin
      full_reg  <= 1'b0;
    end else if (load) begin
      full_reg  <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end
  end

  assign full      = full_reg;
  assign buf_pc    = pc_reg;
  assign buf_instr = instr_reg;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding bus request at a
// time, and produces the registered fetch_data_t bundle for decode.
module fetch
  import fetch_pkg::*;
#(
  parameter addr_t PC_INIT   = PC_INIT_DEFAULT,
  parameter u32    NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     ibus,
  input  logic        stall,
  input  logic        redirect_valid,
  input  addr_t       redirect_pc,
  output fetch_data_t dataF
);

  localparam fetch_data_t BUBBLE = '{valid: 1'b0, pc: '0, raw_instr: NOP_INSTR};

  fetch_state_t state_reg, state_next;
  addr_t        pc_reg, pc_next;
  addr_t        req_addr_reg, req_addr_next;
  addr_t        pending_reg, pending_next;
  fetch_data_t  data_reg, data_next;

  logic         buf_load;
  logic         buf_clear;
  logic         buf_full;
  addr_t        buf_pc;
  u32           buf_instr;

  redirect_t    redirect;
  addr_t        pc_inc;

  assign redirect = '{valid: redirect_valid, pc: align_word(redirect_pc)};
  assign pc_inc   = pc_reg + 64'd4;

  fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_pc    (pc_reg),
    .load_instr (ibus.iresp_data),
    .full       (buf_full),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );

  // State, PC and output registers; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= REQ;
      pc_reg       <= PC_INIT;
      req_addr_reg <= PC_INIT;
      pending_reg  <= PC_INIT;
      data_reg     <= BUBBLE;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
      pending_reg  <= pending_next;
      data_reg     <= data_next;
    end
  end

  // Next-state logic: redirect beats stall beats normal advance in every state.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    req_addr_next = req_addr_reg;
    pending_next  = pending_reg;
    data_next     = data_reg;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;

    case (state_reg)
      REQ: begin
        if (ibus.iresp_data_ok) begin
          if (redirect.valid) begin
            // Returned word is on the wrong path; refetch from the target.
            pc_next       = redirect.pc;
            req_addr_next = redirect.pc;
            data_next     = BUBBLE;
          end else if (stall) begin
            // Decode cannot accept; park the word so it is never refetched.
            buf_load      = 1'b1;
            pc_next       = pc_inc;
            req_addr_next = pc_inc;
            state_next    = HOLD;
          end else begin
            data_next     = '{valid: 1'b1, pc: pc_reg, raw_instr: ibus.iresp_data};
            pc_next       = pc_inc;
            req_addr_next = pc_inc;
          end
        end else begin
          if (redirect.valid) begin
            // Request already on the bus must complete before we move on.
            pending_next = redirect.pc;
            data_next    = BUBBLE;
            state_next   = DROP;
          end else if (!stall) begin
            data_next    = BUBBLE;
          end
        end
      end

      HOLD: begin
        if (redirect.valid) begin
          buf_clear     = 1'b1;
          pc_next       = redirect.pc;
          req_addr_next = redirect.pc;
          data_next     = BUBBLE;
          state_next    = REQ;
        end else if (!stall) begin
          data_next  = '{valid: 1'b1, pc: buf_pc, raw_instr: buf_instr};
          buf_clear  = 1'b1;
          state_next = REQ;
        end
      end

      DROP: begin
        if (redirect.valid) begin
          pending_next = redirect.pc;
        end
        if (redirect.valid || !stall) begin
          data_next = BUBBLE;
        end
        if (ibus.iresp_data_ok) begin
          // The stale response is discarded; the newest redirect target wins.
          pc_next       = redirect.valid ? redirect.pc : pending_reg;
          req_addr_next = redirect.valid ? redirect.pc : pending_reg;
          state_next    = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase
  end

  // Request is live in REQ and DROP; never while reset is asserted.
  assign ibus.ireq_valid = !reset && (state_reg != HOLD);
  assign ibus.ireq_addr  = req_addr_reg;
  assign dataF           = data_reg;

endmodule
